// File: rtl/camera_fifo.sv
// Single-clock 4096x16 FIFO for the camera pixel path. wr_clk and rd_clk are
// the same net, so pointers, count and flags all live in one clock domain.
module camera_fifo #(
  parameter int WR_DEPTH_WIDTH   = 12,
  parameter int RD_DEPTH_WIDTH   = 12,
  parameter int WR_DATA_WIDTH    = 16,
  parameter int RD_DATA_WIDTH    = 16,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                      wr_clk,
  input  logic                      rd_clk,
  input  logic                      wr_rst,
  input  logic                      rd_rst,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  input  logic                      rd_en,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  output logic                      rd_empty,
  output logic [WR_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty
);

  localparam int CW    = WR_DEPTH_WIDTH + 1;
  localparam int DEPTH = 1 << WR_DEPTH_WIDTH;
  localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL  = CW'(ALMOST_FULL_NUM);
  localparam logic [CW-1:0] AEMPTY_LVL = CW'(ALMOST_EMPTY_NUM);

  logic                      rst_s;
  logic [WR_DATA_WIDTH-1:0]  mem_r [0:DEPTH-1];
  logic [WR_DEPTH_WIDTH-1:0] wr_ptr_r;
  logic [RD_DEPTH_WIDTH-1:0] rd_ptr_r;
  logic [CW-1:0]             count_r;
  logic [CW-1:0]             count_nxt_s;
  logic                      full_r;
  logic                      empty_r;
  logic                      afull_r;
  logic                      aempty_r;
  logic                      wr_accept_s;
  logic                      rd_accept_s;
  logic [RD_DATA_WIDTH-1:0]  rd_data_r;

  assign rst_s = wr_rst | rd_rst;

  // Accept decisions and next occupancy; flags are registered from count_nxt_s
  // so they describe the count after the current edge without an extra cycle.
  always_comb begin
    wr_accept_s = wr_en & ~full_r;
    rd_accept_s = rd_en & ~empty_r;
    count_nxt_s = count_r;
    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; left unreset so it maps onto block RAM.
  always_ff @(posedge wr_clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Write pointer, occupancy count and status flags.
  always_ff @(posedge wr_clk or posedge rst_s) begin
    if (rst_s) begin
      wr_ptr_r <= {WR_DEPTH_WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + {{(WR_DEPTH_WIDTH-1){1'b0}}, 1'b1};
      end
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == FULL_LVL);
      empty_r  <= (count_nxt_s == {CW{1'b0}});
      afull_r  <= (count_nxt_s >= AFULL_LVL);
      aempty_r <= (count_nxt_s <= AEMPTY_LVL);
    end
  end

  // Read pointer and the single output register (one-cycle read latency).
  always_ff @(posedge rd_clk or posedge rst_s) begin
    if (rst_s) begin
      rd_ptr_r  <= {RD_DEPTH_WIDTH{1'b0}};
      rd_data_r <= {RD_DATA_WIDTH{1'b0}};
    end else if (rd_accept_s) begin
      rd_ptr_r  <= rd_ptr_r + {{(RD_DEPTH_WIDTH-1){1'b0}}, 1'b1};
      rd_data_r <= mem_r[rd_ptr_r];
    end
  end

  assign wr_full        = full_r;
  assign rd_empty       = empty_r;
  assign almost_full    = afull_r;
  assign almost_empty   = aempty_r;
  assign wr_water_level = count_r;
  assign rd_water_level = count_r;
  assign rd_data        = rd_data_r;

endmodule

// File: tb/tb_camera_fifo.sv
// Directed bench for camera_fifo: fill, drain, simultaneous traffic,
// full/empty boundary collisions and asynchronous reset behaviour.
module tb_camera_fifo;

  logic        clk;
  logic        tb_rst;
  logic        tb_rd_rst;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        rd_en;
  logic        wr_full;
  logic        almost_full;
  logic        rd_empty;
  logic        almost_empty;
  logic [12:0] wr_water_level;
  logic [12:0] rd_water_level;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;

  camera_fifo dut (
    .wr_clk         (clk),
    .rd_clk         (clk),
    .wr_rst         (tb_rst),
    .rd_rst         (tb_rd_rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input int cnt);
    check_val({tag, "_lvl"},   {19'd0, wr_water_level}, cnt);
    check_val({tag, "_rlvl"},  {19'd0, rd_water_level}, cnt);
    check_val({tag, "_full"},  {31'd0, wr_full},        (cnt == 4096) ? 32'd1 : 32'd0);
    check_val({tag, "_empty"}, {31'd0, rd_empty},       (cnt == 0) ? 32'd1 : 32'd0);
    check_val({tag, "_af"},    {31'd0, almost_full},    (cnt >= 1020) ? 32'd1 : 32'd0);
    check_val({tag, "_ae"},    {31'd0, almost_empty},   (cnt <= 4) ? 32'd1 : 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rdata"}, {16'd0, rd_data}, 32'd0);
    check_status(tag, 0);
  endtask

  initial begin
    tb_rst    = 1'b1;
    tb_rd_rst = 1'b0;
    wr_data   = 16'd0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    #3;
    check_reset_outputs("por");
    step();
    tb_rst = 1'b0;
    step();
    check_reset_outputs("idle");

    // fill with 0xFFFF downward; the 4097th word must be dropped
    for (int i = 0; i < 4097; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'hFFFF - 16'(i);
      step();
      check_status("fill", (i < 4096) ? i + 1 : 4096);
      check_val("fill_rdata", {16'd0, rd_data}, 32'd0);
    end
    wr_en = 1'b0;

    // drain; the 4097th read is ignored and rd_data holds 0xF000
    for (int k = 0; k < 4097; k++) begin
      rd_en = 1'b1;
      step();
      check_val("drain_rdata", {16'd0, rd_data}, (k < 4096) ? 32'hFFFF - 32'(k) : 32'hF000);
      check_status("drain", (k < 4096) ? 4095 - k : 0);
    end
    rd_en = 1'b0;

    // preload 10 words, then 20 cycles of simultaneous write and read
    for (int i = 0; i < 10; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'h1000 + 16'(i);
      step();
    end
    check_status("pre_sim", 10);
    for (int j = 0; j < 20; j++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 16'h2000 + 16'(j);
      step();
      check_val("sim_rdata", {16'd0, rd_data}, (j < 10) ? 32'h1000 + 32'(j) : 32'h2000 + 32'(j - 10));
      check_status("sim", 10);
    end
    wr_en = 1'b0;
    for (int j = 20; j < 30; j++) begin
      rd_en = 1'b1;
      step();
      check_val("sim_tail", {16'd0, rd_data}, 32'h2000 + 32'(j - 10));
    end
    rd_en = 1'b0;
    check_status("sim_done", 0);

    // empty + wr + rd: only the write happens, rd_data holds
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 16'hABCD;
    step();
    check_val("bnd_empty_rdata", {16'd0, rd_data}, 32'h2013);
    check_status("bnd_empty", 1);
    wr_en = 1'b0;
    step();
    check_val("bnd_empty_read", {16'd0, rd_data}, 32'hABCD);
    check_status("bnd_empty_rd", 0);
    rd_en = 1'b0;

    // full + wr + rd: only the read happens
    for (int i = 0; i < 4096; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(i);
      step();
    end
    check_status("bnd_fill", 4096);
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 16'h5555;
    step();
    check_val("bnd_full_rdata", {16'd0, rd_data}, 32'h0000);
    check_status("bnd_full", 4095);
    wr_en = 1'b0;
    rd_en = 1'b0;

    // wr_rst clears a nearly full FIFO without a clock edge
    tb_rst = 1'b1;
    #1;
    check_reset_outputs("wrst");
    step();
    tb_rst = 1'b0;

    // rd_rst alone mid-fill at count 500
    for (int i = 0; i < 501; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'h3000 + 16'(i);
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_val("mid_rdata", {16'd0, rd_data}, 32'h3000);
    check_status("mid", 500);
    tb_rd_rst = 1'b1;
    #1;
    check_reset_outputs("rdrst");
    wr_en   = 1'b1;
    wr_data = 16'h9999;
    step();
    check_reset_outputs("rdrst_hold");
    tb_rd_rst = 1'b0;
    wr_data   = 16'h7777;
    step();
    check_status("post_wr", 1);
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_val("post_rdata", {16'd0, rd_data}, 32'h7777);
    check_status("post_rd", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
